// File: rtl/mem_stream_pkg.sv
// Shared types and constants for the buffer-to-stream read sequencer.
package mem_stream_pkg;

  localparam int unsigned AW_DEF  = 8;
  localparam int unsigned DW_DEF  = 32;
  localparam int unsigned MAX_LEN = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A transfer must move between 1 and MAX_LEN words.
  function automatic logic len_legal(input int unsigned len);
    return (len >= 1) && (len <= MAX_LEN);
  endfunction

endpackage

// File: rtl/mem_stream_ctrl_if.sv
// AXI-Stream master/slave bundle carrying the buffer words out.
interface mem_stream_ctrl_if #(
  parameter int unsigned DW = 32
) ();

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/mem_stream_fifo.sv
// Small synchronous FIFO holding {last, data}; flush empties it in one cycle.
module mem_stream_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 33
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = store[rd_ptr];

  // Storage array; no reset needed because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_stream_ctrl.sv
// Walks an address window of the word buffer and streams the words out with TLAST.
module mem_stream_ctrl
  import mem_stream_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF
) (
  input  logic          S_AXI_ACLK,
  input  logic          S_AXI_ARESET,
  input  logic          cfg_start,
  input  logic          cfg_abort,
  input  logic [AW-1:0] cfg_base,
  input  logic [AW:0]   cfg_len,
  input  logic          host_busy,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  mem_stream_ctrl_if.master m_axis,
  output logic          sts_busy,
  output logic          sts_done,
  output logic          sts_err
);

  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FW = DW + 1;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] addr;
  logic [LW-1:0] rem;
  logic          pend;
  logic          pend_last;
  logic [1:0]    inflight;
  logic          err;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic [FW-1:0] fifo_dout;

  logic issue_c;
  logic start_ok_c;
  logic start_bad_c;
  logic abort_c;
  logic push_c;
  logic pop_c;

  // Issue credit, command decode and FIFO handshakes.
  always_comb begin
    issue_c     = 1'b0;
    start_ok_c  = 1'b0;
    start_bad_c = 1'b0;
    abort_c     = cfg_abort && ((state == RUN) || (state == DRAIN));
    push_c      = pend;
    pop_c       = !fifo_empty && m_axis.tready;
    if (state == RUN) begin
      issue_c = (rem != '0) && !host_busy && !fifo_full &&
                ((32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH);
    end
    if ((state == IDLE) && cfg_start && !cfg_abort) begin
      start_ok_c  = len_legal(32'(cfg_len));
      start_bad_c = !len_legal(32'(cfg_len));
    end
  end

  // State register.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) state <= IDLE;
    else              state <= state_nx;
  end

  // Next-state logic; abort wins over everything in an active transfer.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_ok_c)       state_nx = RUN;
        else if (start_bad_c) state_nx = DONE;
      end
      RUN: begin
        if (abort_c)                               state_nx = IDLE;
        else if (issue_c && (rem == LW'(1)))       state_nx = DRAIN;
      end
      DRAIN: begin
        if (abort_c)                               state_nx = IDLE;
        else if ((inflight == 2'd0) && fifo_empty) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address walk, remaining count, read-return tracking and sticky error.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      addr      <= '0;
      rem       <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      inflight  <= 2'd0;
      err       <= 1'b0;
    end else begin
      if (start_ok_c) begin
        addr <= cfg_base;
        rem  <= cfg_len;
        err  <= 1'b0;
      end else if (start_bad_c) begin
        err <= 1'b1;
      end
      if (issue_c) begin
        addr      <= addr + AW'(1);
        rem       <= rem - LW'(1);
        pend_last <= (rem == LW'(1));
      end
      pend <= issue_c && !abort_c;
      if (abort_c) begin
        inflight <= 2'd0;
      end else begin
        case ({issue_c, push_c})
          2'b10:   inflight <= inflight + 2'd1;
          2'b01:   inflight <= inflight - 2'd1;
          default: inflight <= inflight;
        endcase
      end
    end
  end

  mem_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (S_AXI_ACLK),
    .rst   (S_AXI_ARESET),
    .push  (push_c),
    .pop   (pop_c),
    .flush (abort_c),
    .din   ({pend_last, mem_rd_data}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign mem_rd_en     = issue_c;
  assign mem_rd_addr   = addr;
  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_empty ? '0 : fifo_dout[DW-1:0];
  assign m_axis.tlast  = !fifo_empty && fifo_dout[DW];
  assign sts_busy      = (state == RUN) || (state == DRAIN);
  assign sts_done      = (state == DONE);
  assign sts_err       = err;

endmodule

// File: tb/tb_mem_stream_ctrl.sv
// Scoreboard bench for mem_stream_ctrl: model queues filled at start, monitor pops on stream beats.
module tb_mem_stream_ctrl;
  import mem_stream_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic        cfg_abort;
  logic [7:0]  cfg_base;
  logic [8:0]  cfg_len;
  logic        host_busy;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        sts_busy;
  logic        sts_done;
  logic        sts_err;

  mem_stream_ctrl_if #(.DW(32)) axis ();

  mem_stream_ctrl #(.FIFO_DEPTH(DEPTH), .AW(8), .DW(32)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .cfg_start    (cfg_start),
    .cfg_abort    (cfg_abort),
    .cfg_base     (cfg_base),
    .cfg_len      (cfg_len),
    .host_busy    (host_busy),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .m_axis       (axis),
    .sts_busy     (sts_busy),
    .sts_done     (sts_done),
    .sts_err      (sts_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } word_t;

  logic [31:0] buf_mem [256];
  word_t       exp_q [$];
  logic [7:0]  addr_q [$];
  int          n_tests  = 0;
  int          n_fail   = 0;
  int          rd_cnt   = 0;
  int          done_cnt = 0;
  bit          rand_mode = 1'b0;

  // Buffer model: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= buf_mem[mem_rd_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: read-port rules, credit bound and stream scoreboard.
  always @(negedge clk) begin
    word_t e;
    if (!rst) begin
      if (mem_rd_en) begin
        rd_cnt++;
        check("rd_while_host_busy", 32'(host_busy), 32'd0);
        if (addr_q.size() == 0) fail_now("unexpected_read");
        else check("rd_addr", 32'(mem_rd_addr), 32'(addr_q.pop_front()));
      end
      n_tests++;
      assert (32'(dut.fifo_count) + 32'(dut.inflight) <= DEPTH) else begin
        n_fail++;
        $display("FAIL credit: count+inflight=%0d, limit %0d", 32'(dut.fifo_count) + 32'(dut.inflight), DEPTH);
      end
      n_tests++;
      assert (!(dut.push_c && dut.fifo_full)) else begin
        n_fail++;
        $display("FAIL push_into_full: push=1 full=1, required no push while full");
      end
      if (axis.tvalid && axis.tready) begin
        if (exp_q.size() == 0) fail_now("unexpected_word");
        else begin
          e = exp_q.pop_front();
          check("tdata", axis.tdata, e.data);
          check("tlast", 32'(axis.tlast), 32'(e.last));
        end
      end
      if (sts_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      axis.tready = ($urandom_range(0, 3) != 0);
      host_busy   = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    addr_q.delete();
  endtask

  // Drive a start pulse; when modelled, queue the expected words and addresses.
  task automatic start_xfer(input logic [7:0] base, input logic [8:0] len, input bit model);
    word_t w;
    cfg_base  = base;
    cfg_len   = len;
    cfg_start = 1'b1;
    if (model && len >= 1 && len <= 256) begin
      for (int i = 0; i < int'(len); i++) begin
        w.last = (i == int'(len) - 1);
        w.data = buf_mem[8'(int'(base) + i)];
        exp_q.push_back(w);
        addr_q.push_back(8'(int'(base) + i));
      end
    end
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int max, input int d0);
    int k = 0;
    while (done_cnt == d0 && k < max) begin
      tick();
      k++;
    end
    if (done_cnt == d0) fail_now("done_timeout");
    check("done_pulses", 32'(done_cnt), 32'(d0 + 1));
    check("done_one_cycle", 32'(sts_done), 32'd0);
  endtask

  task automatic check_drained(input string name);
    check({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_reads_left"}, 32'(addr_q.size()), 32'd0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_rd_en"},  32'(mem_rd_en),    32'd0);
    check({name, "_tvalid"}, 32'(axis.tvalid),  32'd0);
    check({name, "_tlast"},  32'(axis.tlast),   32'd0);
    check({name, "_tdata"},  axis.tdata,        32'd0);
    check({name, "_busy"},   32'(sts_busy),     32'd0);
    check({name, "_done"},   32'(sts_done),     32'd0);
    check({name, "_err"},    32'(sts_err),      32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int d0;
    int rd0;
    int k;
    logic [8:0] bad_len [2];
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_base = '0;
    cfg_len = '0;
    host_busy = 1'b0;
    axis.tready = 1'b1;
    for (int i = 0; i < 256; i++) buf_mem[i] = 32'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Cycle-exact latency, base 0x10 len 4
    d0 = done_cnt;
    start_xfer(8'h10, 9'd4, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("lat_rd_en", 32'(mem_rd_en), 32'(c >= 1 && c <= 4));
      if (c <= 4) check("lat_rd_addr", 32'(mem_rd_addr), 32'(16 + c - 1));
      check("lat_tvalid", 32'(axis.tvalid), 32'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) begin
        check("lat_tdata", axis.tdata, 32'(16 + c - 3));
        check("lat_tlast", 32'(axis.tlast), 32'(c == 6));
      end
      check("lat_done", 32'(sts_done), 32'(c == 8));
      check("lat_busy", 32'(sts_busy), 32'(c <= 7));
      tick();
    end
    check("lat_done_count", 32'(done_cnt), 32'(d0 + 1));
    check_drained("lat");

    // Address wrap 0xFE..0x01
    d0 = done_cnt;
    start_xfer(8'hFE, 9'd4, 1'b1);
    wait_done(50, d0);
    check_drained("wrap");

    // len 16, TREADY 1010..., host_busy in cycles 2-5
    d0 = done_cnt;
    rd0 = rd_cnt;
    start_xfer(8'($urandom), 9'd16, 1'b1);
    for (int c = 1; c < 300 && done_cnt == d0; c++) begin
      axis.tready = ((c % 2) == 1);
      host_busy   = (c >= 2 && c <= 5);
      tick();
    end
    axis.tready = 1'b1;
    host_busy = 1'b0;
    check("stall_done_count", 32'(done_cnt), 32'(d0 + 1));
    check("stall_reads", 32'(rd_cnt - rd0), 32'd16);
    check_drained("stall");

    // Illegal lengths then a legal start clears the error
    bad_len[0] = 9'd0;
    bad_len[1] = 9'd300;
    for (int j = 0; j < 2; j++) begin
      d0 = done_cnt;
      rd0 = rd_cnt;
      start_xfer(8'h20, bad_len[j], 1'b1);
      check("illegal_err", 32'(sts_err), 32'd1);
      check("illegal_done", 32'(sts_done), 32'd1);
      wait_done(10, d0);
      check("illegal_reads", 32'(rd_cnt - rd0), 32'd0);
      check("illegal_err_sticky", 32'(sts_err), 32'd1);
    end
    d0 = done_cnt;
    start_xfer(8'h33, 9'd1, 1'b1);
    check("err_cleared", 32'(sts_err), 32'd0);
    wait_done(20, d0);
    check_drained("len1");

    // Abort in cycle 10 of a 64-word transfer
    d0 = done_cnt;
    start_xfer(8'($urandom), 9'd64, 1'b1);
    repeat (9) tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    flush_model();
    @(negedge clk);
    check("abort_tvalid", 32'(axis.tvalid), 32'd0);
    check("abort_busy", 32'(sts_busy), 32'd0);
    repeat (5) tick();
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    d0 = done_cnt;
    start_xfer(8'h05, 9'd2, 1'b1);
    wait_done(20, d0);
    check_drained("post_abort");

    // Start while busy is ignored
    d0 = done_cnt;
    rd0 = rd_cnt;
    start_xfer(8'h40, 9'd8, 1'b1);
    repeat (2) tick();
    start_xfer(8'h80, 9'd3, 1'b0);
    wait_done(60, d0);
    check("busy_start_reads", 32'(rd_cnt - rd0), 32'd8);
    check_drained("busy_start");

    // Reset in the middle of a transfer
    start_xfer(8'h70, 9'd20, 1'b1);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    flush_model();
    @(negedge clk);
    check_quiet("mid_reset");
    tick();
    rst = 1'b0;
    tick();
    d0 = done_cnt;
    start_xfer(8'h01, 9'd3, 1'b1);
    wait_done(20, d0);
    check_drained("post_reset");

    // Randomised transfers with random back-pressure, host traffic and aborts
    for (int i = 0; i < 256; i++) buf_mem[i] = $urandom;
    rand_mode = 1'b1;
    for (int it = 0; it < 30; it++) begin
      d0 = done_cnt;
      start_xfer(8'($urandom), 9'($urandom_range(1, 40)), 1'b1);
      if ($urandom_range(0, 4) == 0) begin
        k = $urandom_range(1, 20);
        for (int c = 0; c < k && sts_busy; c++) tick();
        if (sts_busy) begin
          cfg_abort = 1'b1;
          tick();
          cfg_abort = 1'b0;
          flush_model();
          @(negedge clk);
          check("rand_abort_tvalid", 32'(axis.tvalid), 32'd0);
          tick();
          check("rand_abort_no_done", 32'(done_cnt), 32'(d0));
          continue;
        end
      end
      wait_done(400, d0);
      check_drained("rand");
    end
    rand_mode = 1'b0;
    axis.tready = 1'b1;
    host_busy = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stream_ctrl.md
Name: mem_stream_ctrl

Overview:
- Read sequencer for the 256x32 word buffer behind the AXI-Lite register/memory slave.
- On a start command it walks a programmed address window, issues single-cycle reads on a dedicated buffer read port, and emits the words as an AXI-Stream with TLAST.
- The host (AXI-Lite) side always has priority on the buffer; this block yields whenever the host is accessing it.

Parameters:
- FIFO_DEPTH, 4, output buffer entries; must be a power of two and at least 4 to sustain 1 word/cycle.
- AW, 8, buffer word-address width (256 words).
- DW, 32, data width.

Ports:
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESET  in  1  reset, synchronous, active-high.
- cfg_start  in  1  one-cycle start pulse.
- cfg_abort  in  1  one-cycle abort pulse.
- cfg_base  in  AW  first word address.
- cfg_len  in  AW+1  word count; valid range 1..256.
- host_busy  in  1  host is using the buffer this cycle; blocks issue.
- mem_rd_en  out  1  buffer read strobe.
- mem_rd_addr  out  AW  buffer word address.
- mem_rd_data  in  DW  read data, valid the cycle after mem_rd_en.
- M_AXIS_TDATA  out  DW  stream data.
- M_AXIS_TVALID  out  1  stream valid.
- M_AXIS_TLAST  out  1  final word of the transfer.
- M_AXIS_TREADY  in  1  stream ready.
- sts_busy  out  1  transfer in progress.
- sts_done  out  1  one-cycle completion pulse.
- sts_err  out  1  sticky: illegal length; cleared by the next legal start.

Behaviour:
- Reset: state IDLE; FIFO empty; in-flight count 0. All outputs 0, and sts_err cleared.
- States:
  - IDLE: cfg_start with 1 <= cfg_len <= 256 latches base, len and rem=len, clears sts_err, then goes to RUN.
  - cfg_len = 0 or > 256 at start: set sts_err, go to DONE; no reads are issued.
  - RUN: issue rule below. When the last read is issued (rem becomes 0), go to DRAIN.
  - DRAIN: wait until in-flight count = 0 and the FIFO is empty, then go to DONE.
  - DONE: sts_done=1 for exactly one cycle, then IDLE.
- sts_busy = 1 in RUN and DRAIN.
- cfg_start outside IDLE is ignored.
- Issue rule (combinational in RUN):
  - mem_rd_en = rem != 0 and !host_busy and (fifo_count + inflight) < FIFO_DEPTH.
  - mem_rd_addr = current address. After each issue the address increments modulo 256 (0xFF wraps to 0x00) and rem decrements.
- Read return: data returning one cycle after mem_rd_en is written into the FIFO on the following edge. In-flight count is at most 2; the credit check guarantees no overflow.
- TLAST is tagged at issue time on the read where rem = 1 and is stored alongside the data in the FIFO.
- Stream output:
  - M_AXIS_TVALID = FIFO not empty.
  - Pop when TVALID and TREADY.
  - TDATA and TLAST are stable while TVALID && !TREADY.
- Latency, no stalls: start sampled at edge 0; mem_rd_en high in cycle 1; TVALID high in cycle 3. Throughput is 1 word/cycle with TREADY=1 and host_busy=0.
- host_busy: stalls issue only. Reads already in flight still complete. Words are emitted in address order with none dropped.
- Simultaneous FIFO push and pop: count unchanged. A push into a full FIFO is impossible by construction; the bench checks this with an assertion.
- cfg_abort in RUN or DRAIN:
  - Next cycle: state IDLE, FIFO flushed, TVALID=0, in-flight returns discarded.
  - No sts_done pulse.
  - Abort takes priority over a same-cycle start.
- Reset mid-transfer: identical to the reset state, with the FIFO flushed.

Decomposition:
- Shared package mem_stream_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - AW/DW defaults
  - MAX_LEN = 256
- Sub-module mem_stream_fifo: synchronous FIFO of FIFO_DEPTH x (DW+1) holding {last, data}. It has push, pop and flush inputs, and count, empty and full outputs.

Test Plan:
- base=0x10, len=4, TREADY=1, buffer[i]=i -> reads 0x10..0x13 in cycles 1..4; TDATA 0x10..0x13 in cycles 3..6; TLAST only on 0x13; sts_done in cycle 8 (DRAIN exits once the FIFO empties).
- base=0xFE, len=4 -> addresses 0xFE, 0xFF, 0x00, 0x01; stream in that order; TLAST on the 4th word.
- len=16; TREADY toggling 1010...; host_busy high in cycles 2-5 -> exactly 16 words in order; mem_rd_en never high while host_busy; fifo_count+inflight <= FIFO_DEPTH at all times.
- len=0, then len=300 -> sts_err=1 and one sts_done pulse each, no mem_rd_en; a following start with len=1 clears sts_err.
- len=64, cfg_abort in cycle 10 -> TVALID=0 in cycle 11, state IDLE, no sts_done; a new start with len=2 streams correctly with no stale data.
- cfg_start pulsed while busy -> ignored; word count and base are unchanged from the first command.
